// File: rtl/write_seq_gen.sv
// Write-sequence generator: emits a programmable number of addr/data beats
// in one of four pattern modes, with a valid/ready handshake on wen/ready.
module write_seq_gen #(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 8,
    parameter int              CNT_W     = 8,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 8'hca,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  count,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              wen,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t            state, stateNext;
    logic [1:0]        modeQ;
    logic [CNT_W-1:0]  cntQ;
    logic [CNT_W-1:0]  idx;
    logic [15:0]       lfsr;
    logic [15:0]       lfsrNext;
    logic              accept;
    logic              lastBeat;
    logic              loadBeat;
    logic [1:0]        selMode;
    logic [CNT_W-1:0]  selIdx;
    logic [DATA_W-1:0] selLfsr;
    logic [ADDR_W-1:0] beatA;
    logic [DATA_W-1:0] beatD;

    // Mode 2 parks on the base address; every other mode walks upward with wrap.
    function automatic logic [ADDR_W-1:0] beatAddr(input logic [1:0] m,
                                                   input logic [CNT_W-1:0] i);
        logic [ADDR_W-1:0] off;
        off = (m == 2'd2) ? '0 : ADDR_W'(i);
        return ADDR_BASE + off;
    endfunction

    function automatic logic [DATA_W-1:0] beatData(input logic [1:0] m,
                                                   input logic [CNT_W-1:0] i,
                                                   input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] l);
        case (m)
            2'd1:    return l;
            2'd2:    return DATA_W'(i);
            default: return DATA_W'(~a);
        endcase
    endfunction

    assign lfsrNext = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign accept   = (state == RUN) && ready;
    assign lastBeat = (idx == cntQ - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = (count == '0) ? DONE : RUN;
            RUN:  if (ready) begin
                      if (lastBeat)            stateNext = DONE;
                      else if (modeQ == 2'd3)  stateNext = GAP;
                  end
            GAP:  stateNext = RUN;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        wen  = (state == RUN);
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // The beat being loaded is beat 0 on start, idx+1 after an accept in RUN,
    // or the already-advanced idx when leaving the idle GAP cycle.
    always_comb begin
        selMode = (state == IDLE) ? mode : modeQ;
        selIdx  = idx;
        selLfsr = lfsr[DATA_W-1:0];
        if (state == IDLE) begin
            selIdx  = '0;
            selLfsr = LFSR_SEED[DATA_W-1:0];
        end else if (state == RUN) begin
            selIdx  = idx + CNT_W'(1);
            selLfsr = lfsrNext[DATA_W-1:0];
        end
        beatA    = beatAddr(selMode, selIdx);
        beatD    = beatData(selMode, selIdx, beatA, selLfsr);
        loadBeat = ((state == IDLE) && start && (count != '0)) ||
                   (accept && !lastBeat && (modeQ != 2'd3)) ||
                   (state == GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeQ <= '0;
            cntQ  <= '0;
            idx   <= '0;
            lfsr  <= LFSR_SEED;
        end else if ((state == IDLE) && start) begin
            modeQ <= mode;
            cntQ  <= count;
            idx   <= '0;
            lfsr  <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= lfsrNext;
            if (!lastBeat) idx <= idx + CNT_W'(1);
        end
    end

    // addr/data only change when a new beat is presented, so they hold under stall
    // and keep the final beat once the sequence ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            data <= '0;
        end else if (loadBeat) begin
            addr <= beatA;
            data <= beatD;
        end
    end

endmodule

// File: tb/tb_write_seq_gen.sv
// Self-checking bench for write_seq_gen: directed vector table, hand-written
// corner sequences and randomized sequences against a queue-based model.
module tb_write_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] count;
    logic       ready;
    logic [7:0] addr, data, addr2, data2;
    logic       wen, busy, done, wen2, busy2, done2;

    int nVec = 0;
    int nBad = 0;

    typedef struct {
        logic       start;
        logic [1:0] mode;
        logic [7:0] count;
        logic       ready;
        logic       wen;
        logic [7:0] addr;
        logic [7:0] data;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } beat_t;

    vec_t  vecs[$];
    beat_t expQ[$];

    write_seq_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .count(count),
        .ready(ready), .addr(addr), .data(data), .wen(wen), .busy(busy), .done(done)
    );

    write_seq_gen #(.ADDR_BASE(8'hfe)) dutWrap (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .count(count),
        .ready(ready), .addr(addr2), .data(data2), .wen(wen2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Taps 16,14,13,11 as a parity of the masked register, shifted in at bit 0.
    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    function automatic void buildExpected(input logic [7:0] base, input int m, input int c);
        logic [15:0] lf;
        logic [7:0]  a;
        beat_t       b;
        expQ.delete();
        lf = 16'hACE1;
        for (int i = 0; i < c; i++) begin
            a = (m == 2) ? base : 8'((int'(base) + i) % 256);
            b.a = a;
            case (m)
                1:       b.d = lf[7:0];
                2:       b.d = 8'(i % 256);
                default: b.d = 8'(255 - int'(a));
            endcase
            expQ.push_back(b);
            lf = lfsrStep(lf);
        end
    endfunction

    task automatic addVec(input logic st, input logic [1:0] md, input logic [7:0] cn,
                          input logic rd, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic b, input logic dn);
        vec_t v;
        v = '{st, md, cn, rd, w, a, d, b, dn};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] md, input logic [7:0] cn,
                                 input logic rd);
        start = st;
        mode  = md;
        count = cn;
        ready = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runModelSeq(input string tag, input int m, input int c);
        int      budget;
        int      seen;
        logic    prevAcc;
        logic    rdy;
        beat_t   b;
        buildExpected(8'hca, m, c);
        applyStimulus(1'b1, 2'(m), 8'(c), 1'($urandom_range(0, 1)));
        budget  = 4 * c + 8;
        seen    = 0;
        prevAcc = 1'b0;
        while (budget > 0 && !done) begin
            checkOutput({tag, " busy"}, busy, 1);
            if (prevAcc && m == 3) checkOutput({tag, " gap wen"}, wen, 0);
            rdy     = ($urandom_range(0, 9) < 7);
            prevAcc = 1'b0;
            if (wen) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, " extra wen"}, wen, 0);
                end else begin
                    b = expQ[0];
                    checkOutput($sformatf("%s beat%0d addr", tag, seen), addr, b.a);
                    checkOutput($sformatf("%s beat%0d data", tag, seen), data, b.d);
                    if (rdy) begin
                        void'(expQ.pop_front());
                        seen++;
                        prevAcc = 1'b1;
                    end
                end
            end
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), rdy);
            budget--;
        end
        checkOutput({tag, " done reached"}, done, 1);
        checkOutput({tag, " beats transferred"}, seen, c);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput({tag, " idle busy"}, busy, 0);
        checkOutput({tag, " idle done"}, done, 0);
    endtask

    initial begin
        logic [15:0] lf;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        count = 8'd0;
        ready = 1'b1;
        #12;
        checkOutput("reset addr", addr, 8'h00);
        checkOutput("reset data", data, 8'h00);
        checkOutput("reset wen",  wen,  0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0 count 3
        addVec(1, 0, 3, 1,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hcb, 8'h34, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hcc, 8'h33, 1, 0);
        addVec(0, 0, 0, 1,  0, 8'hcc, 8'h33, 1, 1);
        addVec(0, 0, 0, 1,  0, 8'hcc, 8'h33, 0, 0);
        // mode 2 count 3
        addVec(1, 2, 3, 1,  1, 8'hca, 8'h00, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hca, 8'h01, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hca, 8'h02, 1, 0);
        addVec(0, 0, 0, 1,  0, 8'hca, 8'h02, 1, 1);
        addVec(0, 0, 0, 1,  0, 8'hca, 8'h02, 0, 0);
        // mode 3 count 3: wen 1,0,1,0,1
        addVec(1, 3, 3, 1,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 1,  0, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hcb, 8'h34, 1, 0);
        addVec(0, 0, 0, 1,  0, 8'hcb, 8'h34, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hcc, 8'h33, 1, 0);
        addVec(0, 0, 0, 1,  0, 8'hcc, 8'h33, 1, 1);
        addVec(0, 0, 0, 1,  0, 8'hcc, 8'h33, 0, 0);
        // count 0
        addVec(1, 0, 0, 1,  0, 8'hcc, 8'h33, 1, 1);
        addVec(0, 0, 0, 1,  0, 8'hcc, 8'h33, 0, 0);
        // start held while busy is ignored
        addVec(1, 0, 2, 1,  1, 8'hca, 8'h35, 1, 0);
        addVec(1, 1, 9, 1,  1, 8'hcb, 8'h34, 1, 0);
        addVec(1, 2, 5, 1,  0, 8'hcb, 8'h34, 1, 1);
        addVec(0, 0, 0, 1,  0, 8'hcb, 8'h34, 0, 0);
        // ready low for 4 cycles on beat 0
        addVec(1, 0, 2, 0,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 0,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 0,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 0,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 0,  1, 8'hca, 8'h35, 1, 0);
        addVec(0, 0, 0, 1,  1, 8'hcb, 8'h34, 1, 0);
        addVec(0, 0, 0, 1,  0, 8'hcb, 8'h34, 1, 1);
        addVec(0, 0, 0, 1,  0, 8'hcb, 8'h34, 0, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].start, vecs[k].mode, vecs[k].count, vecs[k].ready);
            checkOutput($sformatf("vec%0d wen",  k), wen,  vecs[k].wen);
            checkOutput($sformatf("vec%0d addr", k), addr, vecs[k].addr);
            checkOutput($sformatf("vec%0d data", k), data, vecs[k].data);
            checkOutput($sformatf("vec%0d busy", k), busy, vecs[k].busy);
            checkOutput($sformatf("vec%0d done", k), done, vecs[k].done);
        end

        // LFSR mode, count 4
        lf = 16'hACE1;
        applyStimulus(1'b1, 2'd1, 8'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("lfsr beat%0d wen", i),  wen,  1);
            checkOutput($sformatf("lfsr beat%0d addr", i), addr, 8'(8'hca + i));
            checkOutput($sformatf("lfsr beat%0d data", i), data, lf[7:0]);
            lf = lfsrStep(lf);
            applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        end
        checkOutput("lfsr done", done, 1);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);

        // address wrap on the ADDR_BASE=fe instance
        applyStimulus(1'b1, 2'd0, 8'd3, 1'b1);
        checkOutput("wrap beat0 addr", addr2, 8'hfe);
        checkOutput("wrap beat0 data", data2, 8'h01);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("wrap beat1 addr", addr2, 8'hff);
        checkOutput("wrap beat1 data", data2, 8'h00);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("wrap beat2 addr", addr2, 8'h00);
        checkOutput("wrap beat2 data", data2, 8'hff);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("wrap done", done2, 1);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);

        // asynchronous reset during beat 1 of 3
        applyStimulus(1'b1, 2'd1, 8'd3, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("pre-reset addr", addr, 8'hcb);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset addr", addr, 8'h00);
        checkOutput("async reset data", data, 8'h00);
        checkOutput("async reset wen",  wen,  0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset done", done, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("held reset done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset done", done, 0);
        applyStimulus(1'b1, 2'd1, 8'd1, 1'b1);
        checkOutput("restart addr", addr, 8'hca);
        checkOutput("restart data", data, 8'he1);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("restart done", done, 1);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);

        // randomized sequences against the queue model
        runModelSeq("rand full-count", 1, 255);
        for (int s = 0; s < 40; s++) begin
            runModelSeq($sformatf("rand%0d", s), $urandom_range(0, 3),
                        ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
